mcpu_bus_if: RTL and testbench

Parametrised memory/IO bus interface unit for the multi-cycle CPU.
- Takes one fetch/load/store request at a time from the core datapath.
- Drives the CPU_MIO / mem_w / Addr_out / PC_out / Data_out bus, inserts wait states until MIO_ready, and returns aligned, extended read data.
- Adds what the plain CPU shell lacks: configurable widths, byte/half/word/dword access with byte enables, misalignment detection, bus timeout, and a synchronised, latched INT line.

---
 rtl/mcpu_bus_if.sv | 223 ++++++++++++++++++++++
 tb/tb_mcpu_bus_if.sv | 225 ++++++++++++++++++++++
 2 files changed

// File: rtl/mcpu_bus_if.sv
// Single-request memory/IO bus interface for the multi-cycle CPU: sized, aligned accesses, wait states, timeout, INT latch.
// Accept->BUS next cycle, response one cycle after MIO_ready (or after TIMEOUT waits); req_ready is low until the response retires.
module mcpu_bus_if #(
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 32,
  parameter int TIMEOUT = 255
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                req_valid,
  output logic                req_ready,
  input  logic                req_fetch,
  input  logic                req_write,
  input  logic [1:0]          req_size,
  input  logic                req_signed,
  input  logic [ADDR_W-1:0]   req_addr,
  input  logic [DATA_W-1:0]   req_wdata,
  output logic                rsp_valid,
  output logic [DATA_W-1:0]   rsp_rdata,
  output logic                rsp_err,
  input  logic [DATA_W-1:0]   inst_in,
  input  logic [DATA_W-1:0]   Data_in,
  input  logic                MIO_ready,
  output logic                CPU_MIO,
  output logic                mem_w,
  output logic [DATA_W/8-1:0] mem_be,
  output logic [ADDR_W-1:0]   PC_out,
  output logic [ADDR_W-1:0]   Addr_out,
  output logic [DATA_W-1:0]   Data_out,
  input  logic                INT,
  output logic                int_pending,
  input  logic                int_ack
);

  localparam int BE_W   = DATA_W / 8;
  localparam int LANE_W = $clog2(BE_W);
  localparam logic [15:0] TO_LIMIT = 16'(TIMEOUT);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_BUS  = 2'd1;
  localparam logic [1:0] S_RESP = 2'd2;

  logic [1:0]        r_state;
  logic              r_fetch;
  logic              r_write;
  logic [1:0]        r_size;
  logic              r_signed;
  logic [LANE_W-1:0] r_lane;
  logic              r_err;
  logic [15:0]       r_cnt;
  logic [DATA_W-1:0] r_rdata;
  logic [BE_W-1:0]   r_be;
  logic [ADDR_W-1:0] r_pc_out;
  logic [ADDR_W-1:0] r_addr_out;
  logic [DATA_W-1:0] r_data_out;
  logic              r_int_s1;
  logic              r_int_s2;
  logic              r_int_s3;
  logic              r_int_pend;

  logic              w_misalign;
  logic              w_illegal;
  logic              w_req_err;
  logic [BE_W-1:0]   w_be_base;
  logic [BE_W-1:0]   w_be;
  logic [DATA_W-1:0] w_wrep;
  logic [DATA_W-1:0] w_raw;
  logic [DATA_W-1:0] w_shift;
  logic [DATA_W-1:0] w_mask;
  logic              w_msb;
  logic              w_sext;
  logic [DATA_W-1:0] w_ext;
  logic              w_int_edge;

  // Request decode: alignment, legality, lane enables and replicated store data
  always_comb begin
    w_misalign = 1'b0;
    w_be_base  = '0;
    w_wrep     = req_wdata;
    case (req_size)
      2'b00: begin
        w_be_base = BE_W'(8'h01);
        w_wrep    = {(DATA_W/8){req_wdata[7:0]}};
      end
      2'b01: begin
        w_misalign = req_addr[0];
        w_be_base  = BE_W'(8'h03);
        w_wrep     = {(DATA_W/16){req_wdata[15:0]}};
      end
      2'b10: begin
        w_misalign = |req_addr[1:0];
        w_be_base  = BE_W'(8'h0F);
        w_wrep     = {(DATA_W/32){req_wdata[31:0]}};
      end
      default: begin
        w_misalign = |req_addr[2:0];
        w_be_base  = BE_W'(8'hFF);
        w_wrep     = req_wdata;
      end
    endcase
  end

  assign w_illegal = ((req_size == 2'b11) && (DATA_W == 32)) || (req_fetch && req_write);
  assign w_req_err = w_misalign | w_illegal;
  assign w_be      = w_be_base << req_addr[LANE_W-1:0];

  // Read path: right-align the addressed lanes, then mask and optionally sign-extend
  assign w_raw   = r_fetch ? inst_in : Data_in;
  assign w_shift = w_raw >> {r_lane, 3'b000};

  always_comb begin
    w_mask = '1;
    w_msb  = w_shift[DATA_W-1];
    case (r_size)
      2'b00: begin
        w_mask = DATA_W'(8'hFF);
        w_msb  = w_shift[7];
      end
      2'b01: begin
        w_mask = DATA_W'(16'hFFFF);
        w_msb  = w_shift[15];
      end
      2'b10: begin
        w_mask = DATA_W'(32'hFFFF_FFFF);
        w_msb  = w_shift[31];
      end
      default: begin
        w_mask = '1;
        w_msb  = w_shift[DATA_W-1];
      end
    endcase
  end

  assign w_sext = r_signed & ~r_fetch & w_msb;
  assign w_ext  = (w_shift & w_mask) | ({DATA_W{w_sext}} & ~w_mask);

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state    <= S_IDLE;
      r_fetch    <= 1'b0;
      r_write    <= 1'b0;
      r_size     <= 2'b00;
      r_signed   <= 1'b0;
      r_lane     <= '0;
      r_err      <= 1'b0;
      r_cnt      <= '0;
      r_rdata    <= '0;
      r_be       <= '0;
      r_pc_out   <= '0;
      r_addr_out <= '0;
      r_data_out <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (req_valid) begin
            r_fetch  <= req_fetch;
            r_write  <= req_write;
            r_size   <= req_size;
            r_signed <= req_signed;
            r_lane   <= req_addr[LANE_W-1:0];
            r_cnt    <= '0;
            r_rdata  <= '0;
            if (w_req_err) begin
              r_err   <= 1'b1;
              r_state <= S_RESP;
            end else begin
              r_err      <= 1'b0;
              r_be       <= w_be;
              r_data_out <= w_wrep;
              if (req_fetch) r_pc_out <= req_addr;
              else           r_addr_out <= req_addr;
              r_state <= S_BUS;
            end
          end
        end
        S_BUS: begin
          if (MIO_ready) begin
            r_rdata <= r_write ? '0 : w_ext;
            r_state <= S_RESP;
          end else if (r_cnt == TO_LIMIT) begin
            r_err   <= 1'b1;
            r_state <= S_RESP;
          end else begin
            r_cnt <= r_cnt + 16'd1;
          end
        end
        S_RESP:  r_state <= S_IDLE;
        default: r_state <= S_IDLE;
      endcase
    end
  end

  // Ack loses to a coincident new edge so that interrupt is never dropped
  assign w_int_edge = r_int_s2 & ~r_int_s3;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_int_s1   <= 1'b0;
      r_int_s2   <= 1'b0;
      r_int_s3   <= 1'b0;
      r_int_pend <= 1'b0;
    end else begin
      r_int_s1 <= INT;
      r_int_s2 <= r_int_s1;
      r_int_s3 <= r_int_s2;
      if (w_int_edge)   r_int_pend <= 1'b1;
      else if (int_ack) r_int_pend <= 1'b0;
    end
  end

  assign req_ready   = (r_state == S_IDLE);
  assign CPU_MIO     = (r_state == S_BUS);
  assign mem_w       = CPU_MIO & r_write;
  assign mem_be      = CPU_MIO ? r_be : '0;
  assign rsp_valid   = (r_state == S_RESP);
  assign rsp_rdata   = rsp_valid ? r_rdata : '0;
  assign rsp_err     = rsp_valid & r_err;
  assign PC_out      = r_pc_out;
  assign Addr_out    = r_addr_out;
  assign Data_out    = r_data_out;
  assign int_pending = r_int_pend;

endmodule

// File: tb/tb_mcpu_bus_if.sv
// Directed bench for mcpu_bus_if (32-bit bus, TIMEOUT=4).
module tb_mcpu_bus_if;

  logic        clk = 1'b0;
  logic        reset;
  logic        req_valid;
  logic        req_ready;
  logic        req_fetch;
  logic        req_write;
  logic [1:0]  req_size;
  logic        req_signed;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        rsp_valid;
  logic [31:0] rsp_rdata;
  logic        rsp_err;
  logic [31:0] inst_in;
  logic [31:0] Data_in;
  logic        MIO_ready;
  logic        CPU_MIO;
  logic        mem_w;
  logic [3:0]  mem_be;
  logic [31:0] PC_out;
  logic [31:0] Addr_out;
  logic [31:0] Data_out;
  logic        INT;
  logic        int_pending;
  logic        int_ack;

  int total = 0;
  int bad   = 0;

  mcpu_bus_if #(.ADDR_W(32), .DATA_W(32), .TIMEOUT(4)) dut (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready), .req_fetch(req_fetch),
    .req_write(req_write), .req_size(req_size), .req_signed(req_signed),
    .req_addr(req_addr), .req_wdata(req_wdata),
    .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
    .inst_in(inst_in), .Data_in(Data_in), .MIO_ready(MIO_ready),
    .CPU_MIO(CPU_MIO), .mem_w(mem_w), .mem_be(mem_be),
    .PC_out(PC_out), .Addr_out(Addr_out), .Data_out(Data_out),
    .INT(INT), .int_pending(int_pending), .int_ack(int_ack)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Present a request for one accepting edge; returns in the first BUS/RESP cycle
  task automatic issue(input logic f, input logic w, input logic [1:0] sz,
                       input logic sg, input logic [31:0] a, input logic [31:0] wd);
    req_fetch  = f;
    req_write  = w;
    req_size   = sz;
    req_signed = sg;
    req_addr   = a;
    req_wdata  = wd;
    req_valid  = 1'b1;
    tick();
    req_valid  = 1'b0;
  endtask

  initial begin
    reset = 1'b1; req_valid = 1'b0; req_fetch = 1'b0; req_write = 1'b0;
    req_size = 2'b00; req_signed = 1'b0; req_addr = '0; req_wdata = '0;
    inst_in = '0; Data_in = '0; MIO_ready = 1'b0; INT = 1'b0; int_ack = 1'b0;
    tick();
    tick();
    chk("rst_req_ready", 64'(req_ready), 64'd1);
    chk("rst_cpu_mio",   64'(CPU_MIO),   64'd0);
    chk("rst_rsp_valid", 64'(rsp_valid), 64'd0);
    chk("rst_mem_be",    64'(mem_be),    64'd0);
    chk("rst_pc_out",    64'(PC_out),    64'd0);
    chk("rst_int_pend",  64'(int_pending), 64'd0);
    reset = 1'b0;
    tick();

    // 1: aligned word load, zero wait
    MIO_ready = 1'b1; Data_in = 32'h8000_00F0;
    issue(1'b0, 1'b0, 2'b10, 1'b0, 32'h104, 32'h0);
    chk("t1_cpu_mio",  64'(CPU_MIO),   64'd1);
    chk("t1_addr_out", 64'(Addr_out),  64'h104);
    chk("t1_mem_be",   64'(mem_be),    64'hF);
    chk("t1_mem_w",    64'(mem_w),     64'd0);
    chk("t1_ready_lo", 64'(req_ready), 64'd0);
    chk("t1_no_rsp",   64'(rsp_valid), 64'd0);
    tick();
    chk("t1_rsp_valid", 64'(rsp_valid), 64'd1);
    chk("t1_rdata",     64'(rsp_rdata), 64'h8000_00F0);
    chk("t1_err",       64'(rsp_err),   64'd0);
    chk("t1_mio_off",   64'(CPU_MIO),   64'd0);
    tick();
    chk("t1_idle",      64'(req_ready), 64'd1);
    chk("t1_rsp_once",  64'(rsp_valid), 64'd0);

    // 2: signed byte load, 3 wait states
    MIO_ready = 1'b0; Data_in = 32'h80AA_BBCC;
    issue(1'b0, 1'b0, 2'b00, 1'b1, 32'h103, 32'h0);
    chk("t2_mem_be", 64'(mem_be), 64'h8);
    tick();
    tick();
    chk("t2_wait_mio", 64'(CPU_MIO), 64'd1);
    tick();
    MIO_ready = 1'b1;
    chk("t2_no_rsp_n4", 64'(rsp_valid), 64'd0);
    tick();
    chk("t2_rsp_n5",   64'(rsp_valid), 64'd1);
    chk("t2_rdata_s",  64'(rsp_rdata), 64'hFFFF_FF80);
    tick();
    issue(1'b0, 1'b0, 2'b00, 1'b0, 32'h103, 32'h0);
    tick();
    chk("t2_rdata_u", 64'(rsp_rdata), 64'h0000_0080);
    tick();

    // 3: byte store
    issue(1'b0, 1'b1, 2'b00, 1'b0, 32'h22, 32'h5A);
    chk("t3_data_out", 64'(Data_out), 64'h5A5A_5A5A);
    chk("t3_mem_be",   64'(mem_be),   64'h4);
    chk("t3_mem_w",    64'(mem_w),    64'd1);
    tick();
    chk("t3_rsp",       64'(rsp_valid), 64'd1);
    chk("t3_rdata",     64'(rsp_rdata), 64'd0);
    chk("t3_mem_w_off", 64'(mem_w),     64'd0);
    chk("t3_be_off",    64'(mem_be),    64'd0);
    chk("t3_data_hold", 64'(Data_out),  64'h5A5A_5A5A);
    tick();

    // 4: misaligned half, fetch+write, timeout
    issue(1'b0, 1'b0, 2'b01, 1'b0, 32'h11, 32'h0);
    chk("t4_mis_rsp", 64'(rsp_valid), 64'd1);
    chk("t4_mis_err", 64'(rsp_err),   64'd1);
    chk("t4_mis_mio", 64'(CPU_MIO),   64'd0);
    tick();
    issue(1'b1, 1'b1, 2'b10, 1'b0, 32'h0, 32'h0);
    chk("t4_fw_rsp", 64'(rsp_valid), 64'd1);
    chk("t4_fw_err", 64'(rsp_err),   64'd1);
    chk("t4_fw_mio", 64'(CPU_MIO),   64'd0);
    tick();
    MIO_ready = 1'b0;
    issue(1'b0, 1'b0, 2'b10, 1'b0, 32'h200, 32'h0);
    for (int i = 0; i < 5; i++) begin
      chk($sformatf("t4_to_bus%0d", i), 64'(CPU_MIO), 64'd1);
      tick();
    end
    chk("t4_to_rsp",   64'(rsp_valid), 64'd1);
    chk("t4_to_err",   64'(rsp_err),   64'd1);
    chk("t4_to_rdata", 64'(rsp_rdata), 64'd0);
    tick();

    // 5: fetch, then data loads keep PC_out
    MIO_ready = 1'b1; inst_in = 32'h2008_0005;
    issue(1'b1, 1'b0, 2'b10, 1'b0, 32'h400, 32'h0);
    chk("t5_pc_out", 64'(PC_out), 64'h400);
    tick();
    chk("t5_rdata", 64'(rsp_rdata), 64'h2008_0005);
    tick();
    Data_in = 32'h8765_1234;
    issue(1'b0, 1'b0, 2'b01, 1'b1, 32'h302, 32'h0);
    chk("t5_pc_hold", 64'(PC_out),   64'h400);
    chk("t5_addr",    64'(Addr_out), 64'h302);
    chk("t5_be_half", 64'(mem_be),   64'hC);
    tick();
    chk("t5_half_s", 64'(rsp_rdata), 64'hFFFF_8765);
    tick();

    // 6: interrupt synchroniser, ack, edge-vs-ack, reset mid-BUS
    INT = 1'b1;
    tick();
    tick();
    chk("t6_int_early", 64'(int_pending), 64'd0);
    tick();
    chk("t6_int_set", 64'(int_pending), 64'd1);
    int_ack = 1'b1;
    tick();
    int_ack = 1'b0;
    chk("t6_int_ack", 64'(int_pending), 64'd0);
    tick();
    tick();
    chk("t6_held_once", 64'(int_pending), 64'd0);
    INT = 1'b0;
    tick(); tick(); tick();
    INT = 1'b1;
    tick();
    tick();
    int_ack = 1'b1;
    tick();
    int_ack = 1'b0;
    chk("t6_edge_wins", 64'(int_pending), 64'd1);

    MIO_ready = 1'b0;
    issue(1'b0, 1'b1, 2'b10, 1'b0, 32'h500, 32'hDEAD_BEEF);
    chk("t6_bus_mio", 64'(CPU_MIO), 64'd1);
    chk("t6_bus_w",   64'(mem_w),   64'd1);
    reset = 1'b1;
    tick();
    chk("t6_rst_mio",   64'(CPU_MIO),     64'd0);
    chk("t6_rst_w",     64'(mem_w),       64'd0);
    chk("t6_rst_rsp",   64'(rsp_valid),   64'd0);
    chk("t6_rst_ready", 64'(req_ready),   64'd1);
    chk("t6_rst_addr",  64'(Addr_out),    64'd0);
    chk("t6_rst_dout",  64'(Data_out),    64'd0);
    chk("t6_rst_int",   64'(int_pending), 64'd0);
    reset = 1'b0;
    INT = 1'b0;
    tick();
    chk("t6_no_late_rsp", 64'(rsp_valid), 64'd0);
    tick();
    chk("t6_still_none", 64'(rsp_valid), 64'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
